avg_unpool_layer: RTL and testbench

Backward/upsampling counterpart of the CNN core's 2x2 average-pooling layer. Takes a pooled 3x3 feature map (or gradient), expands each element into a 2x2 block of a 6x6 map, and scales it by 1/4 in average-backward mode or replicates it unchanged in nearest-neighbour mode. Pixels are emitted one per accepted handshake in raster order. Each pixel is also written into a full 6x6 output array, which is valid when `done` rises.

---
 rtl/avg_unpool_layer.sv | 110 +++++++++++
 tb/tb_avg_unpool_layer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_unpool_layer.sv
// 2x upsampling of a pooled feature map: each input element becomes a 2x2 block,
// scaled by 1/4 (average-backward) or copied (nearest-neighbour), streamed in raster order.
module avg_unpool_layer #(
  parameter int IN_W = 3,
  parameter int IN_H = 3,
  parameter int MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] in_fm [0:IN_W*IN_H-1],
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_data,
  output logic [5:0]         out_index,
  output logic signed [31:0] out_fm [0:4*IN_W*IN_H-1]
);

  localparam int OW = 2 * IN_W;
  localparam int OH = 2 * IN_H;
  localparam int NI = IN_W * IN_H;
  localparam int NO = OW * OH;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic signed [31:0] r_in_buf [0:NI-1];
  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [5:0]         r_idx;

  logic               w_accept;
  logic               w_fire;
  logic               w_last;
  int                 w_src;
  logic signed [31:0] w_src_val;
  logic signed [31:0] w_px;

  assign w_fire    = (r_state == S_EMIT) && out_ready;
  assign w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_src     = (int'(r_row) >> 1) * IN_W + (int'(r_col) >> 1);
  assign w_src_val = r_in_buf[w_src];
  assign w_px      = (MODE == 0) ? (w_src_val >>> 2) : w_src_val;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_fire && w_last) w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Snapshot is taken only on an accepted start, so in_fm may change freely mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_idx <= '0;
      for (int i = 0; i < NI; i++) r_in_buf[i] <= '0;
      for (int i = 0; i < NO; i++) out_fm[i] <= '0;
    end else if (w_accept) begin
      r_col <= '0;
      r_row <= '0;
      r_idx <= '0;
      for (int i = 0; i < NI; i++) r_in_buf[i] <= in_fm[i];
    end else if (w_fire) begin
      out_fm[r_idx] <= w_px;
      r_idx <= r_idx + 6'd1;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign busy      = (r_state == S_EMIT);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_EMIT);
  assign out_data  = out_valid ? w_px : '0;
  assign out_index = out_valid ? r_idx : '0;

endmodule

// File: tb/tb_avg_unpool_layer.sv
// Bench for avg_unpool_layer: MODE 0 and MODE 1 instances run side by side
// against a floor-division / replication reference model.
module tb_avg_unpool_layer;

  localparam int NI = 9;
  localparam int NO = 36;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic out_ready;
  logic signed [31:0] in_fm [0:NI-1];

  logic busy0, done0, valid0, busy1, done1, valid1;
  logic signed [31:0] data0, data1;
  logic [5:0] idx0, idx1;
  logic signed [31:0] fm0 [0:NO-1];
  logic signed [31:0] fm1 [0:NO-1];

  logic signed [31:0] snap [0:NI-1];
  logic signed [31:0] exp0 [0:NO-1];
  logic signed [31:0] exp1 [0:NO-1];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  avg_unpool_layer #(.IN_W(3), .IN_H(3), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_fm(in_fm),
    .busy(busy0), .done(done0), .out_valid(valid0),
    .out_ready(out_ready), .out_data(data0),
    .out_index(idx0), .out_fm(fm0)
  );

  avg_unpool_layer #(.IN_W(3), .IN_H(3), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_fm(in_fm),
    .busy(busy1), .done(done1), .out_valid(valid1),
    .out_ready(out_ready), .out_data(data1),
    .out_index(idx1), .out_fm(fm1)
  );

  function automatic logic signed [31:0] px(input int mode, input int k);
    int r, c;
    longint s, q;
    r = k / 6;
    c = k % 6;
    s = longint'(snap[(r / 2) * 3 + c / 2]);
    if (mode == 1) return 32'(s);
    q = (s - (((s % 4) + 4) % 4)) / 4;
    return 32'(q);
  endfunction

  task automatic check_all_fm(input string name);
    for (int i = 0; i < NO; i++) begin
      ncmp++;
      if (fm0[i] !== exp0[i] || fm1[i] !== exp1[i]) begin
        nerr++;
        $display("FAIL %s out_fm[%0d]: got m0=%0d m1=%0d want m0=%0d m1=%0d",
                 name, i, fm0[i], fm1[i], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    ncmp++;
    if ({busy0, done0, valid0, busy1, done1, valid1} !== 6'b0 ||
        data0 !== 0 || idx0 !== 0 || data1 !== 0 || idx1 !== 0) begin
      nerr++;
      $display("FAIL %s ctrl: got b/d/v=%b%b%b %b%b%b data=%0d,%0d idx=%0d,%0d want all 0",
               name, busy0, done0, valid0, busy1, done1, valid1,
               data0, data1, idx0, idx1);
    end
    for (int i = 0; i < NO; i++) begin
      exp0[i] = '0;
      exp1[i] = '0;
    end
    check_all_fm(name);
  endtask

  // rmode: 0 ready always, 1 toggle starting low, 2 random
  task automatic run_frame(input string name, input int rmode,
                           input int ms_at, input int rst_at,
                           input int want_cyc);
    int k, cyc, stalls;
    logic signed [31:0] e0, e1;
    for (int i = 0; i < NI; i++) snap[i] = in_fm[i];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0; stalls = 0;
    while (k < NO && cyc < 400) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 1);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!out_ready) stalls++;
      if (k == ms_at) begin
        start = 1'b1;
        for (int i = 0; i < NI; i++) in_fm[i] = $urandom;
      end else begin
        start = 1'b0;
      end
      if (k == rst_at) begin
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state({name, "_rst"});
        return;
      end
      e0 = px(0, k);
      e1 = px(1, k);
      ncmp++;
      if (!valid0 || !valid1 || !busy0 || !busy1 || done0 || done1 ||
          idx0 !== 6'(k) || idx1 !== 6'(k) ||
          data0 !== e0 || data1 !== e1) begin
        nerr++;
        $display("FAIL %s pix%0d: got v=%b%b b=%b%b d=%b%b idx=%0d,%0d data=%0d,%0d want v=11 b=11 d=00 idx=%0d data=%0d,%0d",
                 name, k, valid0, valid1, busy0, busy1, done0, done1,
                 idx0, idx1, data0, data1, k, e0, e1);
      end
      ncmp++;
      if (fm0[35] !== exp0[35] || fm1[35] !== exp1[35]) begin
        nerr++;
        $display("FAIL %s hold35 at pix%0d: got %0d,%0d want %0d,%0d",
                 name, k, fm0[35], fm1[35], exp0[35], exp1[35]);
      end
      if (out_ready) begin
        exp0[k] = e0;
        exp1[k] = e1;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ncmp++;
    if (cyc >= 400) begin
      nerr++;
      $display("FAIL %s timeout: got %0d pixels want %0d", name, k, NO);
    end else if (!done0 || !done1 || busy0 || busy1 || valid0 ||
                 cyc != NO + stalls ||
                 (want_cyc > 0 && cyc != want_cyc)) begin
      nerr++;
      $display("FAIL %s end: got done=%b%b busy=%b%b cyc=%0d want done=11 busy=00 cyc=%0d",
               name, done0, done1, busy0, busy1, cyc, NO + stalls);
    end
    check_all_fm(name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NI; i++) in_fm[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_avg_ramp;
    for (int i = 0; i < NI; i++) in_fm[i] = 32'(4 * (i + 1));
    run_frame("ramp", 0, -1, -1, 36);
    ncmp++;
    if (fm0[0] !== 1 || fm0[2] !== 2 || fm0[4] !== 3 || fm0[6] !== 1 ||
        fm0[30] !== 7 || fm0[32] !== 8 || fm0[35] !== 9) begin
      nerr++;
      $display("FAIL ramp_literal: got %0d %0d %0d %0d %0d %0d %0d want 1 2 3 1 7 8 9",
               fm0[0], fm0[2], fm0[4], fm0[6], fm0[30], fm0[32], fm0[35]);
    end
  endtask

  task automatic test_negatives;
    for (int i = 0; i < NI; i++) in_fm[i] = 0;
    in_fm[0] = -5;
    in_fm[1] = -1;
    in_fm[2] = -4;
    in_fm[3] = 7;
    run_frame("neg", 0, -1, -1, 36);
    ncmp++;
    if (fm0[0] !== -2 || fm0[1] !== -2 || fm0[6] !== -2 || fm0[7] !== -2 ||
        fm0[2] !== -1 || fm0[3] !== -1 || fm0[4] !== -1 || fm0[12] !== 1) begin
      nerr++;
      $display("FAIL neg_literal: got %0d %0d %0d %0d %0d %0d %0d %0d want -2 -2 -2 -2 -1 -1 -1 1",
               fm0[0], fm0[1], fm0[6], fm0[7], fm0[2], fm0[3], fm0[4], fm0[12]);
    end
  endtask

  task automatic test_mode1_max;
    for (int i = 0; i < NI; i++) in_fm[i] = $urandom;
    in_fm[4] = 32'h7FFF_FFFF;
    run_frame("nn_max", 0, -1, -1, 36);
    ncmp++;
    if (fm1[14] !== 32'h7FFF_FFFF || fm1[15] !== 32'h7FFF_FFFF ||
        fm1[20] !== 32'h7FFF_FFFF || fm1[21] !== 32'h7FFF_FFFF) begin
      nerr++;
      $display("FAIL nn_max_literal: got %h %h %h %h want 7fffffff",
               fm1[14], fm1[15], fm1[20], fm1[21]);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < NI; i++) in_fm[i] = 32'(4 * (i + 1));
    run_frame("toggle", 1, -1, -1, 72);
  endtask

  task automatic test_midrun;
    for (int i = 0; i < NI; i++) in_fm[i] = $urandom;
    run_frame("midrun", 0, 10, 20, 0);
    for (int i = 0; i < NI; i++) in_fm[i] = $urandom;
    run_frame("after_rst", 0, -1, -1, 36);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < NI; i++) in_fm[i] = $urandom;
    run_frame("b2b", 0, -1, -1, 36);
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NI; i++) begin
        case ($urandom_range(0, 3))
          0: in_fm[i] = 32'sh8000_0000;
          1: in_fm[i] = 32'(int'($urandom_range(0, 15)) - 8);
          default: in_fm[i] = $urandom;
        endcase
      end
      run_frame("random", 2, -1, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_avg_ramp();
    test_negatives();
    test_mode1_max();
    test_backpressure();
    test_midrun();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
